irq_ctrl: RTL and testbench

//  Interrupt controller for the timer/peripheral bus behind the CPU address bridge.

---
 rtl/irq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: edge-detected pending bits, mask, global enable,
// single request to CP0 held in service until the handler writes end-of-interrupt.
module irq_ctrl #(
   parameter int NUM_SRC = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [3:0]         dev_addr,
   input  logic [31:0]        dev_wd,
   input  logic               dev_we,
   output logic [31:0]        dev_rd,
   output logic               irq_out,
   input  logic               irq_ack,
   output logic [2:0]         irq_id
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   logic [1:0]         rstSync;
   logic               rstSyncN;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] mask;
   logic               en;
   logic [NUM_SRC-1:0] prevSrc;
   logic [1:0]         state;

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] ackClr;
   logic [NUM_SRC-1:0] pendNext;
   logic [2:0]         winId;
   logic               wrPend;
   logic               wrMask;
   logic               wrCtrl;
   logic               wrVect;
   logic [1:0]         stateNext;
   logic               irqOutNext;
   logic [2:0]         irqIdNext;
   logic               unusedWd;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rstSync <= 2'b00;
      end else begin
         rstSync <= {rstSync[0], 1'b1};
      end
   end

   assign rstSyncN = rstSync[1];

   assign wrPend   = dev_we && (dev_addr == 4'h0);
   assign wrMask   = dev_we && (dev_addr == 4'h4);
   assign wrCtrl   = dev_we && (dev_addr == 4'h8);
   assign wrVect   = dev_we && (dev_addr == 4'hC);
   assign rise     = irq_src & ~prevSrc;
   assign req      = pend & mask;
   assign w1c      = wrPend ? dev_wd[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
   // A rising edge wins over a clear of the same bit in the same cycle.
   assign pendNext = (pend & ~(w1c | ackClr)) | rise;
   assign unusedWd = ^dev_wd[31:NUM_SRC];

   // Lowest-index pending-and-enabled source wins; also the one-hot ack clear.
   always_comb begin
      winId  = 3'd0;
      ackClr = {NUM_SRC{1'b0}};
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         winId     = req[i] ? 3'(i) : winId;
         ackClr[i] = (state == REQ) && irq_ack && (irq_id == 3'(i));
      end
   end

   // Request FSM next-state and registered-output decode.
   always_comb begin
      stateNext  = state;
      irqOutNext = irq_out;
      irqIdNext  = irq_id;
      case (state)
         IDLE: begin
            if (en && (|req)) begin
               stateNext  = REQ;
               irqOutNext = 1'b1;
               irqIdNext  = winId;
            end else begin
               stateNext  = IDLE;
               irqOutNext = 1'b0;
            end
         end
         REQ: begin
            if (irq_ack) begin
               stateNext  = SERVICE;
               irqOutNext = 1'b0;
            end else if (!req[irq_id] || !en) begin
               stateNext  = IDLE;
               irqOutNext = 1'b0;
            end else begin
               stateNext  = REQ;
               irqOutNext = 1'b1;
            end
         end
         SERVICE: begin
            irqOutNext = 1'b0;
            if (wrVect) begin
               stateNext = IDLE;
            end else begin
               stateNext = SERVICE;
            end
         end
         default: begin
            stateNext  = IDLE;
            irqOutNext = 1'b0;
         end
      endcase
   end

   // Register file, edge history and FSM state.
   always_ff @(posedge clk or negedge rstSyncN) begin
      if (!rstSyncN) begin
         pend    <= {NUM_SRC{1'b0}};
         mask    <= {NUM_SRC{1'b0}};
         en      <= 1'b0;
         prevSrc <= {NUM_SRC{1'b0}};
         state   <= IDLE;
         irq_out <= 1'b0;
         irq_id  <= 3'd0;
      end else begin
         pend    <= pendNext;
         prevSrc <= irq_src;
         state   <= stateNext;
         irq_out <= irqOutNext;
         irq_id  <= irqIdNext;
         if (wrMask) begin
            mask <= dev_wd[NUM_SRC-1:0];
         end else begin
            mask <= mask;
         end
         if (wrCtrl) begin
            en <= dev_wd[0];
         end else begin
            en <= en;
         end
      end
   end

   // Register read mux.
   always_comb begin
      dev_rd = 32'h0;
      case (dev_addr)
         4'h0:    dev_rd = {{(32-NUM_SRC){1'b0}}, pend};
         4'h4:    dev_rd = {{(32-NUM_SRC){1'b0}}, mask};
         4'h8:    dev_rd = {31'h0, en};
         4'hC:    dev_rd = {(state == SERVICE), 28'h0, irq_id};
         default: dev_rd = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a vector table for the main request/ack/EOI flow
// followed by hand-written sequences for retract, masking, level-hold and reset.
module tb_irq_ctrl;

   logic        clk;
   logic        reset_n;
   logic [5:0]  irq_src;
   logic [3:0]  dev_addr;
   logic [31:0] dev_wd;
   logic        dev_we;
   logic [31:0] dev_rd;
   logic        irq_out;
   logic        irq_ack;
   logic [2:0]  irq_id;

   int checks = 0;
   int passes = 0;

   irq_ctrl #(.NUM_SRC(6)) dut (
      .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .dev_addr(dev_addr),
      .dev_wd(dev_wd), .dev_we(dev_we), .dev_rd(dev_rd), .irq_out(irq_out),
      .irq_ack(irq_ack), .irq_id(irq_id)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   typedef struct {
      logic [5:0]  src;
      logic        ack;
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic        expOut;
      logic [2:0]  expId;
      logic [3:0]  ra;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecs[16];

   task automatic cyc();
      @(posedge clk);
      #1;
      dev_we  = 1'b0;
      irq_ack = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      dev_we   = 1'b1;
      dev_addr = a;
      dev_wd   = d;
      cyc();
   endtask

   task automatic chkOut(input string nm, input logic eo, input logic [2:0] ei);
      checks++;
      if (irq_out === eo && irq_id === ei) passes++;
      else $display("FAIL %s: irq_out=%0b irq_id=%0d, required irq_out=%0b irq_id=%0d",
                    nm, irq_out, irq_id, eo, ei);
   endtask

   task automatic chkRd(input string nm, input logic [3:0] a, input logic [31:0] exp);
      dev_addr = a;
      #1;
      checks++;
      if (dev_rd === exp) passes++;
      else $display("FAIL %s: read[0x%0h]=0x%08h, required 0x%08h", nm, a, dev_rd, exp);
   endtask

   task automatic waitDrop(input string nm);
      for (int k = 0; k < 3 && irq_out !== 1'b0; k++) cyc();
      chkOut(nm, 1'b0, irq_id);
   endtask

   initial begin
      vecs[0]  = '{6'h00, 1'b0, 1'b1, 4'h4, 32'h3F,       1'b0, 3'd0, 4'h4, 32'h3F};
      vecs[1]  = '{6'h00, 1'b0, 1'b1, 4'h8, 32'h1,        1'b0, 3'd0, 4'h8, 32'h1};
      vecs[2]  = '{6'h08, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 3'd0, 4'h0, 32'h08};
      vecs[3]  = '{6'h08, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 3'd3, 4'h0, 32'h08};
      vecs[4]  = '{6'h08, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 3'd3, 4'hC, 32'h80000003};
      vecs[5]  = '{6'h00, 1'b0, 1'b1, 4'hC, 32'h0,        1'b0, 3'd3, 4'hC, 32'h3};
      vecs[6]  = '{6'h12, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 3'd3, 4'h0, 32'h12};
      vecs[7]  = '{6'h12, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 3'd1, 4'h0, 32'h12};
      vecs[8]  = '{6'h00, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 3'd1, 4'hC, 32'h80000001};
      vecs[9]  = '{6'h00, 1'b0, 1'b1, 4'hC, 32'h0,        1'b0, 3'd1, 4'h0, 32'h10};
      vecs[10] = '{6'h00, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 3'd4, 4'hC, 32'h4};
      vecs[11] = '{6'h00, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 3'd4, 4'h0, 32'h0};
      vecs[12] = '{6'h00, 1'b0, 1'b1, 4'hC, 32'h0,        1'b0, 3'd4, 4'hC, 32'h4};
      vecs[13] = '{6'h00, 1'b0, 1'b1, 4'h2, 32'hFFFFFFFF, 1'b0, 3'd4, 4'h4, 32'h3F};
      vecs[14] = '{6'h00, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 3'd4, 4'h2, 32'h0};
      vecs[15] = '{6'h00, 1'b0, 1'b1, 4'h4, 32'hFFFFFFFF, 1'b0, 3'd4, 4'h4, 32'h3F};

      reset_n  = 1'b1;
      irq_src  = 6'h00;
      dev_addr = 4'h0;
      dev_wd   = 32'h0;
      dev_we   = 1'b0;
      irq_ack  = 1'b0;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chkOut("reset out", 1'b0, 3'd0);
      chkRd("reset PEND", 4'h0, 32'h0);
      chkRd("reset MASK", 4'h4, 32'h0);
      chkRd("reset CTRL", 4'h8, 32'h0);
      chkRd("reset VECT", 4'hC, 32'h0);
      #3 reset_n = 1'b1;
      repeat (3) cyc();

      // Main flow: single source, simultaneous sources, register decode.
      for (int i = 0; i < 16; i++) begin
         irq_src  = vecs[i].src;
         irq_ack  = vecs[i].ack;
         dev_we   = vecs[i].we;
         dev_addr = vecs[i].wa;
         dev_wd   = vecs[i].wd;
         cyc();
         chkOut($sformatf("vec%0d out", i), vecs[i].expOut, vecs[i].expId);
         chkRd($sformatf("vec%0d read", i), vecs[i].ra, vecs[i].expRd);
      end

      // Retract by W1C of the requested source.
      irq_src = 6'h04; cyc();
      chkRd("t4 pend set", 4'h0, 32'h04);
      irq_src = 6'h00; cyc();
      chkOut("t4 req", 1'b1, 3'd2);
      wr(4'h0, 32'h04);
      chkRd("t4 w1c", 4'h0, 32'h0);
      waitDrop("t4 retract");
      chkRd("t4 idle", 4'hC, 32'h2);

      // W1C and a new rise on the same bit: pending stays set.
      irq_src = 6'h04; cyc();
      irq_src = 6'h00; cyc();
      chkOut("t4b req", 1'b1, 3'd2);
      irq_src = 6'h04;
      wr(4'h0, 32'h04);
      chkRd("t4b set wins", 4'h0, 32'h04);
      cyc();
      chkOut("t4b still req", 1'b1, 3'd2);
      irq_src = 6'h00; irq_ack = 1'b1; cyc();
      wr(4'hC, 32'h0);
      chkRd("t4b eoi", 4'hC, 32'h2);

      // Masked source latches pending but is not requested until unmasked.
      wr(4'h4, 32'h0);
      irq_src = 6'h01; cyc();
      irq_src = 6'h00;
      chkRd("t5 pend", 4'h0, 32'h01);
      cyc();
      chkOut("t5 masked", 1'b0, 3'd2);
      wr(4'h4, 32'h01);
      chkOut("t5 unmask+1", 1'b0, 3'd2);
      cyc();
      chkOut("t5 unmask+2", 1'b1, 3'd0);
      irq_ack = 1'b1; cyc();
      wr(4'hC, 32'h0);

      // Level held high sets pending only once.
      wr(4'h4, 32'h3F);
      irq_src = 6'h20; cyc();
      chkRd("t6 pend", 4'h0, 32'h20);
      cyc();
      chkOut("t6 req", 1'b1, 3'd5);
      irq_ack = 1'b1; cyc();
      repeat (17) cyc();
      chkRd("t6 no reset", 4'h0, 32'h0);
      chkRd("t6 service", 4'hC, 32'h80000005);
      wr(4'hC, 32'h0);
      cyc(); cyc();
      chkOut("t6 idle", 1'b0, 3'd5);
      chkRd("t6 pend after", 4'h0, 32'h0);
      irq_src = 6'h00;

      // Spurious ack and EOI in IDLE.
      wr(4'h4, 32'h0);
      irq_src = 6'h02; cyc();
      irq_src = 6'h00;
      chkRd("spur pend", 4'h0, 32'h02);
      irq_ack = 1'b1; cyc();
      chkRd("spur ack pend", 4'h0, 32'h02);
      chkRd("spur ack vect", 4'hC, 32'h5);
      chkOut("spur ack out", 1'b0, 3'd5);
      wr(4'hC, 32'h0);
      chkRd("spur eoi vect", 4'hC, 32'h5);

      // Global disable retracts a request.
      wr(4'h4, 32'h3F);
      cyc();
      chkOut("en req", 1'b1, 3'd1);
      wr(4'h8, 32'h0);
      waitDrop("en retract");
      chkRd("en idle", 4'hC, 32'h1);
      chkRd("en pend kept", 4'h0, 32'h02);
      wr(4'h0, 32'h02);
      chkRd("en pend clr", 4'h0, 32'h0);

      // Asynchronous reset in the middle of a request.
      wr(4'h8, 32'h1);
      irq_src = 6'h01; cyc();
      irq_src = 6'h00; cyc();
      chkOut("mid req", 1'b1, 3'd0);
      #3 reset_n = 1'b0;
      #1;
      chkOut("async rst out", 1'b0, 3'd0);
      chkRd("async rst PEND", 4'h0, 32'h0);
      chkRd("async rst MASK", 4'h4, 32'h0);
      chkRd("async rst CTRL", 4'h8, 32'h0);
      cyc();
      reset_n = 1'b1;
      repeat (3) cyc();
      chkOut("post rst out", 1'b0, 3'd0);
      chkRd("post rst VECT", 4'hC, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
